vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Downstream consumer of the 25 MHz pixel PLL (clock_out/locked); generates 640x480@60 VGA timing.
// - Qualifies PLL lock, then runs horizontal/vertical counters producing sync, blanking, pixel coordinates and frame strobe.
// - Feeds the pong renderer and the VGA pin drivers.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_FP 16, H_SYNC 96, H_BP 48 : horizontal porches/sync (H_TOTAL = 800)
// - V_ACTIVE 480 : visible lines
// - V_FP 10, V_SYNC 2, V_BP 33 : vertical porches/sync (V_TOTAL = 525)
// - SYNC_POL 0 : sync level during pulse (0 = active-low, 640x480 standard)
// - LOCK_WAIT 16 : consecutive locked cycles required before timing starts (>=1)
// PORTS
// - clock        in   1  pixel clock (PLL clock_out, 25 MHz)
// - reset_n      in   1  asynchronous active-low reset
// - locked       in   1  PLL lock (PLL locked output), sampled on clock
// - running      out  1  timing generator active (lock qualified)
// - hsync        out  1  horizontal sync, polarity per SYNC_POL
// - vsync        out  1  vertical sync, polarity per SYNC_POL
// - active       out  1  1 when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
// - pixel_x      out 10  horizontal counter 0..H_TOTAL-1
// - pixel_y      out 10  vertical counter 0..V_TOTAL-1
// - frame_start  out  1  one-cycle pulse at pixel_x==0, pixel_y==0
// - rgb          out 12  test pattern {R4,G4,B4}; only with VGA_TESTPAT_EN
// BEHAVIOUR
// - Reset (reset_n low, async): running=0, lock_cnt=0, pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_POL, active=0, frame_start=0, rgb=0.
// - Lock filter: locked==0 -> lock_cnt=0, running=0 next edge. locked==1 -> lock_cnt++ (saturating);
//   running rises on the edge where lock_cnt reaches LOCK_WAIT, i.e. LOCK_WAIT cycles after locked first sampled high.
// - States: WAIT_LOCK (running=0) -> RUN when lock_cnt==LOCK_WAIT; RUN -> WAIT_LOCK on any cycle locked samples 0.
// - WAIT_LOCK: counters held at 0, outputs at reset values (idle sync level, active=0, frame_start=0).
// - RUN: pixel_x increments each clock; at H_TOTAL-1 wraps to 0 and pixel_y increments;
//   pixel_y wraps to 0 after V_TOTAL-1 (at pixel_x wrap). First RUN cycle shows pixel_x=0, pixel_y=0.
// - All outputs registered and mutually aligned: in the cycle pixel_x==N, hsync/active/frame_start/rgb describe pixel N.
// - hsync = SYNC_POL when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
// - vsync = SYNC_POL when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
// - frame_start=1 exactly in the cycle pixel_x==0 && pixel_y==0 && running, including the first RUN cycle.
// - Lock loss mid-frame: next edge returns to WAIT_LOCK, counters to 0, frame abandoned; restart requires full LOCK_WAIT.
// - Lock glitch (locked low 1 cycle) during WAIT_LOCK restarts lock_cnt from 0.
// - Counter widths fixed 10 bits; parameters must give H_TOTAL, V_TOTAL <= 1024.
// CONFIGURATION
// - Macro VGA_TESTPAT_EN defined: rgb port present; during active, 8 vertical colour bars of 80 px
//   (bar = pixel_x[9:0]/80: white, yellow, cyan, green, magenta, red, blue, black; channels 4'hF or 4'h0);
//   rgb=0 whenever active=0 or running=0.
// - Undefined: rgb port and pattern logic absent; all other behaviour identical.
// TESTING
// - Reset, locked=1 from cycle 0 -> running=0 for 16 cycles, rises on 16th edge; frame_start=1 with pixel_x=0,pixel_y=0 same cycle.
// - One full frame in RUN -> exactly 800*525=420000 cycles between frame_start pulses; hsync low for 96 cycles starting pixel_x=656.
// - Vertical timing -> vsync low exactly during pixel_y 490..491 (1600 cycles); active high 640 cycles/line, 480 lines/frame.
// - Drop locked at pixel_x=300, pixel_y=200 for 1 cycle -> next edge running=0, pixel_x=pixel_y=0, hsync=vsync=1; restart after 16 locked cycles.
// - locked toggling 1x10,0x1,1x16 -> running rises only after the final 16-cycle run.
// - reset_n asserted mid-line asynchronously -> outputs reach reset values without a clock edge.
// - VGA_TESTPAT_EN: pixel_x=85,pixel_y=10 -> rgb=12'hFF0; pixel_x=700 -> rgb=12'h000; macro undefined -> builds without rgb.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Purpose: 640x480@60 VGA timing generator fed by the 25 MHz pixel PLL.
//   Waits for LOCK_WAIT consecutive locked cycles, then runs horizontal and
//   vertical counters producing sync, blanking, pixel coordinates and a
//   frame strobe. All outputs are registered and aligned to pixel_x/pixel_y.
// Optional feature: define VGA_TESTPAT_EN to add the rgb port carrying an
//   8-bar colour test pattern; without it the rgb port and logic are absent.
// Ports:
//   clock       in   1  pixel clock (PLL clock_out)
//   reset_n     in   1  asynchronous active-low reset
//   locked      in   1  PLL lock indication
//   running     out  1  timing generator active (lock qualified)
//   hsync       out  1  horizontal sync (level SYNC_POL during pulse)
//   vsync       out  1  vertical sync (level SYNC_POL during pulse)
//   active      out  1  visible-area flag
//   pixel_x     out 10  horizontal counter
//   pixel_y     out 10  vertical counter
//   frame_start out  1  one-cycle pulse at pixel (0,0)
//   rgb         out 12  {R4,G4,B4} test pattern (VGA_TESTPAT_EN only)
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int LOCK_WAIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  output logic       running,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
`ifdef VGA_TESTPAT_EN
  output logic       frame_start,
  output logic [11:0] rgb
`else
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = $clog2(LOCK_WAIT + 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_WAIT);

  typedef enum logic [0:0] {WAIT_LOCK, RUN} state_t;

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_lockCnt, w_lockCntNext;
  logic [9:0]       r_pixelX, r_pixelY, w_xNext, w_yNext;
  logic             r_hsync, r_vsync, r_active, r_frameStart;
  logic             w_runNext, w_hsNext, w_vsNext, w_activeNext, w_fsNext;

  // Lock filter and state transition. The counter saturates so a long
  // locked period cannot wrap back and look like a fresh lock.
  always_comb begin
    w_lockCntNext = '0;
    w_stateNext   = r_state;
    if (locked) begin
      w_lockCntNext = (r_lockCnt == LOCK_MAX) ? r_lockCnt : r_lockCnt + 1'b1;
    end
    case (r_state)
      WAIT_LOCK: if (locked && (w_lockCntNext == LOCK_MAX)) w_stateNext = RUN;
      RUN:       if (!locked) w_stateNext = WAIT_LOCK;
      default:   w_stateNext = WAIT_LOCK;
    endcase
  end

  // Counters advance only while staying in RUN; entering RUN or dropping
  // back to WAIT_LOCK both load (0,0), so the first RUN cycle is pixel 0.
  always_comb begin
    w_xNext   = '0;
    w_yNext   = '0;
    w_runNext = (w_stateNext == RUN);
    if ((r_state == RUN) && w_runNext) begin
      if (r_pixelX == H_LAST) begin
        w_yNext = (r_pixelY == V_LAST) ? 10'd0 : r_pixelY + 10'd1;
      end else begin
        w_xNext = r_pixelX + 10'd1;
        w_yNext = r_pixelY;
      end
    end
  end

  // Decode from the next coordinates so the registered flags line up with
  // the registered counters in the same cycle.
  always_comb begin
    w_hsNext     = ~SYNC_POL;
    w_vsNext     = ~SYNC_POL;
    w_activeNext = 1'b0;
    w_fsNext     = 1'b0;
    if (w_runNext) begin
      if ((w_xNext >= HS_START) && (w_xNext < HS_END)) w_hsNext = SYNC_POL;
      if ((w_yNext >= VS_START) && (w_yNext < VS_END)) w_vsNext = SYNC_POL;
      w_activeNext = (w_xNext < H_ACT) && (w_yNext < V_ACT);
      w_fsNext     = (w_xNext == 10'd0) && (w_yNext == 10'd0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= WAIT_LOCK;
      r_lockCnt    <= '0;
      r_pixelX     <= '0;
      r_pixelY     <= '0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_active     <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_lockCnt    <= w_lockCntNext;
      r_pixelX     <= w_xNext;
      r_pixelY     <= w_yNext;
      r_hsync      <= w_hsNext;
      r_vsync      <= w_vsNext;
      r_active     <= w_activeNext;
      r_frameStart <= w_fsNext;
    end
  end

  assign running     = (r_state == RUN);
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign pixel_x     = r_pixelX;
  assign pixel_y     = r_pixelY;
  assign frame_start = r_frameStart;

`ifdef VGA_TESTPAT_EN
  logic [9:0]  w_bar;
  logic [11:0] w_rgbNext;
  logic [11:0] r_rgb;

  // Eight 80-pixel bars: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    w_bar     = w_xNext / 10'd80;
    w_rgbNext = 12'h000;
    if (w_activeNext) begin
      case (w_bar[2:0])
        3'd0:    w_rgbNext = 12'hFFF;
        3'd1:    w_rgbNext = 12'hFF0;
        3'd2:    w_rgbNext = 12'h0FF;
        3'd3:    w_rgbNext = 12'h0F0;
        3'd4:    w_rgbNext = 12'hF0F;
        3'd5:    w_rgbNext = 12'hF00;
        3'd6:    w_rgbNext = 12'h00F;
        default: w_rgbNext = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rgb <= 12'h000;
    else          r_rgb <= w_rgbNext;
  end

  assign rgb = r_rgb;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Horizontal timing is the standard
// 800-pixel line; the vertical parameters are shortened (40 visible lines,
// 50 total) so a full frame is 40000 cycles instead of 420000.
module tb_vga_timing_gen;

  localparam int H_TOTAL   = 800;
  localparam int TB_V_ACT  = 40;
  localparam int TB_V_FP   = 4;
  localparam int TB_V_SYNC = 2;
  localparam int TB_V_BP   = 4;
  localparam int V_TOTAL   = TB_V_ACT + TB_V_FP + TB_V_SYNC + TB_V_BP;
  localparam int FRAME     = H_TOTAL * V_TOTAL;
  localparam int LOCK_WAIT = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       locked = 1'b0;
  logic       running, hsync, vsync, active, frame_start;
  logic [9:0] pixel_x, pixel_y;
`ifdef VGA_TESTPAT_EN
  logic [11:0] rgb;
`endif

  int errors = 0;
  int checks = 0;
  int kNow = 0;
  int activeCnt = 0, vsLowCnt = 0, hsLowLine0 = 0;
  int fsCount = 0, lastFsK = 0, framePeriod = 0;

  typedef struct {
    int          x;
    int          y;
    bit          hs;
    bit          vs;
    bit          act;
    bit          fs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[20];

  always #5 clock = ~clock;

  vga_timing_gen #(
    .V_ACTIVE (TB_V_ACT),
    .V_FP     (TB_V_FP),
    .V_SYNC   (TB_V_SYNC),
    .V_BP     (TB_V_BP),
    .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .locked     (locked),
    .running    (running),
    .hsync      (hsync),
    .vsync      (vsync),
    .active     (active),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
`ifdef VGA_TESTPAT_EN
    .frame_start(frame_start),
    .rgb        (rgb)
`else
    .frame_start(frame_start)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " running"}, 32'(running), 32'd0);
    checkOutput({tag, " pixel_x"}, 32'(pixel_x), 32'd0);
    checkOutput({tag, " pixel_y"}, 32'(pixel_y), 32'd0);
    checkOutput({tag, " hsync"}, 32'(hsync), 32'd1);
    checkOutput({tag, " vsync"}, 32'(vsync), 32'd1);
    checkOutput({tag, " active"}, 32'(active), 32'd0);
    checkOutput({tag, " frame_start"}, 32'(frame_start), 32'd0);
`ifdef VGA_TESTPAT_EN
    checkOutput({tag, " rgb"}, 32'(rgb), 32'h000);
`endif
  endtask

  task automatic stepCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic sampleStats();
    if (kNow < FRAME) begin
      if (active) activeCnt++;
      if (!vsync) vsLowCnt++;
      if ((kNow < H_TOTAL) && !hsync) hsLowLine0++;
    end
    if (frame_start) begin
      fsCount++;
      if ((kNow > 0) && (framePeriod == 0)) framePeriod = kNow - lastFsK;
      lastFsK = kNow;
    end
  endtask

  // Advance to cycle 'target' counted from the first RUN cycle.
  task automatic applyStimulus(input int target);
    while (kNow < target) begin
      stepCycle();
      kNow++;
      sampleStats();
    end
  endtask

  initial begin
    int sawRun;

    //         x    y   hs vs act fs rgb
    vecs[0]  = '{1,   0,  1, 1, 1, 0, 12'hFFF};
    vecs[1]  = '{639, 0,  1, 1, 1, 0, 12'h000};
    vecs[2]  = '{640, 0,  1, 1, 0, 0, 12'h000};
    vecs[3]  = '{655, 0,  1, 1, 0, 0, 12'h000};
    vecs[4]  = '{656, 0,  0, 1, 0, 0, 12'h000};
    vecs[5]  = '{751, 0,  0, 1, 0, 0, 12'h000};
    vecs[6]  = '{752, 0,  1, 1, 0, 0, 12'h000};
    vecs[7]  = '{799, 0,  1, 1, 0, 0, 12'h000};
    vecs[8]  = '{0,   1,  1, 1, 1, 0, 12'hFFF};
    vecs[9]  = '{85,  10, 1, 1, 1, 0, 12'hFF0};
    vecs[10] = '{700, 10, 0, 1, 0, 0, 12'h000};
    vecs[11] = '{400, 20, 1, 1, 1, 0, 12'hF00};
    vecs[12] = '{639, 39, 1, 1, 1, 0, 12'h000};
    vecs[13] = '{0,   40, 1, 1, 0, 0, 12'h000};
    vecs[14] = '{799, 43, 1, 1, 0, 0, 12'h000};
    vecs[15] = '{0,   44, 1, 0, 0, 0, 12'h000};
    vecs[16] = '{700, 45, 0, 0, 0, 0, 12'h000};
    vecs[17] = '{0,   46, 1, 1, 0, 0, 12'h000};
    vecs[18] = '{799, 49, 1, 1, 0, 0, 12'h000};
    vecs[19] = '{0,   50, 1, 1, 1, 1, 12'hFFF};

    // Reset with locked already high
    locked = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clock);
    checkIdle("reset");
    reset_n = 1'b1;

    sawRun = 0;
    for (int i = 1; i < LOCK_WAIT; i++) begin
      stepCycle();
      if (running) sawRun++;
    end
    checkOutput("lock early running", 32'(sawRun), 32'd0);
    stepCycle();
    checkOutput("first run running", 32'(running), 32'd1);
    checkOutput("first run frame_start", 32'(frame_start), 32'd1);
    checkOutput("first run pixel_x", 32'(pixel_x), 32'd0);
    checkOutput("first run pixel_y", 32'(pixel_y), 32'd0);
    checkOutput("first run active", 32'(active), 32'd1);

    kNow = 0;
    sampleStats();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].y * H_TOTAL + vecs[i].x);
      checkOutput($sformatf("vec%0d pixel_x", i), 32'(pixel_x), 32'(vecs[i].x));
      checkOutput($sformatf("vec%0d pixel_y", i), 32'(pixel_y), 32'(vecs[i].y % V_TOTAL));
      checkOutput($sformatf("vec%0d hsync", i), 32'(hsync), 32'(vecs[i].hs));
      checkOutput($sformatf("vec%0d vsync", i), 32'(vsync), 32'(vecs[i].vs));
      checkOutput($sformatf("vec%0d active", i), 32'(active), 32'(vecs[i].act));
      checkOutput($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
      checkOutput($sformatf("vec%0d running", i), 32'(running), 32'd1);
`ifdef VGA_TESTPAT_EN
      checkOutput($sformatf("vec%0d rgb", i), 32'(rgb), 32'(vecs[i].rgb));
`endif
    end

    checkOutput("hsync low cycles line0", 32'(hsLowLine0), 32'd96);
    checkOutput("active cycles frame", 32'(activeCnt), 32'(640 * TB_V_ACT));
    checkOutput("vsync low cycles", 32'(vsLowCnt), 32'(2 * H_TOTAL));
    checkOutput("frame period", 32'(framePeriod), 32'(FRAME));
    checkOutput("frame_start pulses", 32'(fsCount), 32'd2);

    // Lock loss mid-frame
    applyStimulus(FRAME + 20 * H_TOTAL + 300);
    checkOutput("pre-drop pixel_x", 32'(pixel_x), 32'd300);
    checkOutput("pre-drop pixel_y", 32'(pixel_y), 32'd20);
    locked = 1'b0;
    stepCycle();
    checkIdle("lock drop");
    locked = 1'b1;
    sawRun = 0;
    for (int i = 1; i < LOCK_WAIT; i++) begin
      stepCycle();
      if (running) sawRun++;
    end
    checkOutput("relock early running", 32'(sawRun), 32'd0);
    stepCycle();
    checkOutput("relock running", 32'(running), 32'd1);
    checkOutput("relock frame_start", 32'(frame_start), 32'd1);
    checkOutput("relock pixel_x", 32'(pixel_x), 32'd0);

    // Glitch during WAIT_LOCK: 1x10, 0x1, 1x16
    locked = 1'b0;
    stepCycle();
    checkOutput("glitch leave running", 32'(running), 32'd0);
    sawRun = 0;
    locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (running) sawRun++;
    end
    locked = 1'b0;
    stepCycle();
    if (running) sawRun++;
    locked = 1'b1;
    for (int i = 1; i < LOCK_WAIT; i++) begin
      stepCycle();
      if (running) sawRun++;
    end
    checkOutput("glitch early running", 32'(sawRun), 32'd0);
    stepCycle();
    checkOutput("glitch final running", 32'(running), 32'd1);

    // Asynchronous reset mid-line
    repeat (500) stepCycle();
    checkOutput("pre-reset pixel_x", 32'(pixel_x), 32'd500);
    checkOutput("pre-reset active", 32'(active), 32'd1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 checkIdle("async reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
